tx_scheduler: RTL



---
 rtl/tx_scheduler_if.sv | 27 ++
 rtl/tx_scheduler.sv | 115 +++++++++++
 2 files changed

// File: rtl/tx_scheduler_if.sv
// Scheduler-side bundle: requester handshake plus the frame transmitter hand-off.
// The slave modport is the scheduler; the master modport is the sources/transmitter side.
interface tx_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic                       sched_en;
    logic [NUM_REQ-1:0]         req;
    logic [136*NUM_REQ-1:0]     req_packet;
    logic [NUM_REQ-1:0]         req_test_mode;
    logic [NUM_REQ-1:0]         ack;
    logic [NUM_REQ-1:0]         done;
    logic                       tx_start;
    logic [135:0]               tx_packet;
    logic                       tx_test_mode;
    logic                       busy;
    logic [2:0]                 owner;

    modport master (
        output sched_en, req, req_packet, req_test_mode,
        input  ack, done, tx_start, tx_packet, tx_test_mode, busy, owner
    );

    modport slave (
        input  sched_en, req, req_packet, req_test_mode,
        output ack, done, tx_start, tx_packet, tx_test_mode, busy, owner
    );
endinterface

// File: rtl/tx_scheduler.sv
// Round-robin sharing of one serial frame transmitter between NUM_REQ packet sources.
// Latches the winner's packet, starts the frame, times it from the header length, then forces a gap.
module tx_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    tx_scheduler_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_GAP} state_t;

    state_t            state;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  win;
    logic [7:0]        cnt;
    logic [3:0]        gap_cnt;
    logic              done_pend;
    logic              grant;
    logic [135:0]      pkt_arr [NUM_REQ];

    // First set request scanning ptr+1, ptr+2, ... wrapping modulo NUM_REQ.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                  input logic [IDX_W-1:0]   p);
        logic [IDX_W-1:0]   w;
        logic [NUM_REQ-1:0] sh;
        logic               found;
        int                 idx;
        w     = p;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(p) + k) % NUM_REQ;
            sh  = r >> idx;
            if (!found && sh[0]) begin
                w     = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            pkt_arr[i] = bus.req_packet[136*i +: 136];
        end
    end

    assign win   = rr_pick(bus.req, ptr);
    assign grant = (state == S_IDLE) && bus.sched_en && (|bus.req);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            ptr              <= IDX_W'(NUM_REQ - 1);
            cnt              <= '0;
            gap_cnt          <= '0;
            done_pend        <= 1'b0;
            bus.ack          <= '0;
            bus.done         <= '0;
            bus.tx_start     <= 1'b0;
            bus.tx_packet    <= '0;
            bus.tx_test_mode <= 1'b0;
            bus.busy         <= 1'b0;
            bus.owner        <= '0;
        end else begin
            bus.ack      <= '0;
            bus.done     <= '0;
            bus.tx_start <= 1'b0;
            done_pend    <= 1'b0;
            // done trails the end of the busy count by one cycle so it lands at tx_start + 49 + 8L
            if (done_pend) begin
                bus.done[ptr] <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (grant) begin
                        bus.tx_packet    <= pkt_arr[win];
                        bus.tx_test_mode <= bus.req_test_mode[win];
                        bus.ack[win]     <= 1'b1;
                        bus.owner        <= 3'(win);
                        ptr              <= win;
                        bus.busy         <= 1'b1;
                        state            <= S_START;
                    end
                end
                S_START: begin
                    bus.tx_start <= 1'b1;
                    cnt          <= 8'd47 + {1'b0, bus.tx_packet[131:128], 3'b000};
                    state        <= S_BUSY;
                end
                S_BUSY: begin
                    if (cnt == 8'd0) begin
                        done_pend <= 1'b1;
                        gap_cnt   <= 4'(GAP_CYCLES - 1);
                        state     <= S_GAP;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == 4'd0) begin
                        bus.busy <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
